timer_share_ctrl: RTL and testbench
===================================

Name: timer_share_ctrl

Overview:
Round-robin controller that time-shares one COUNTER instance (async-reset up-counter with sync clear and enable) among N_REQ requesters that each need a programmable delay.
- Arbitrates requests and latches the winner's period.
- Sequences the counter through clear then count.
- Pulses a per-requester done when the period elapses.
- Sits beside the shared counter; the counter's clr/en inputs are driven only by this block, and its cnt_out feeds back here.

Parameters:
N_REQ, 4, number of requesters (2..8)
COUNT_WIDTH, 5, counter width; must equal the shared COUNTER's COUNT_WIDTH

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req  input  N_REQ  per-requester request level; held until done or withdrawn
period_i  input  N_REQ*COUNT_WIDTH  packed per-requester delay; requester k occupies bits [k*COUNT_WIDTH +: COUNT_WIDTH]
gnt  output  N_REQ  one-hot grant, all-zero when idle
done  output  N_REQ  one-cycle completion pulse for the granted requester
busy  output  1  high whenever state is not IDLE
cnt_clr  output  1  to COUNTER clr
cnt_en  output  1  to COUNTER en
cnt_val  input  COUNT_WIDTH  from COUNTER cnt_out

Behaviour:
- Reset (async) values:
  - state=IDLE, rr pointer=0, idx_r=0, period_r=0.
  - gnt, done, busy, cnt_clr and cnt_en are all 0 while rst is high and after it deasserts.
  - Reset mid-transaction aborts silently: no done pulse.
- FSM states: IDLE, CLEAR, COUNT, DONE.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... mod N_REQ.
  - Latch idx_r and period_r = period_i slice of the winner; go to CLEAR.
  - If req == 0, stay in IDLE.
- CLEAR (1 cycle): cnt_clr=1, cnt_en=0, gnt[idx_r]=1; go to COUNT.
- COUNT:
  - gnt[idx_r]=1.
  - cnt_en = (cnt_val != period_r), a combinational function of cnt_val.
  - When cnt_val == period_r: cnt_en=0 and go to DONE.
  - COUNT therefore lasts period_r+1 cycles, with cnt_val = 0..period_r.
- DONE (1 cycle): done[idx_r]=1, gnt[idx_r]=1; ptr = (idx_r+1) mod N_REQ; go to IDLE.
- gnt, done, busy and cnt_clr are decoded from state and idx_r only (Moore). cnt_en is the only output depending on an input.
- Latency: request sampled in IDLE at edge T0 → CLEAR at T1, COUNT T2..T(2+P), DONE at T(3+P). There is at least one IDLE cycle between transactions.
- Withdrawal: if req[idx_r]=0 while in CLEAR or COUNT:
  - Next state is IDLE; no done pulse.
  - ptr = (idx_r+1) mod N_REQ.
  - The counter is left as-is; the next CLEAR resets it.
- Period changes: period_i changes after grant are ignored (period_r is held). Requests from other requesters are ignored while busy.
- Boundary cases:
  - period_r=0: COUNT lasts 1 cycle and cnt_en never asserts.
  - period_r=2^COUNT_WIDTH-1: the counter reaches its maximum without wrapping. cnt_en never asserts at maximum, so the COUNTER never wraps.
- req must drop by the cycle after done. A req still high in IDLE is treated as a new request.
- At most one gnt bit and one done bit are ever set.

Test Plan:
All scenarios use N_REQ=4, COUNT_WIDTH=5, with a real COUNTER instance attached.
1. Single request (req=0010, period_1=3, req sampled at T0) → gnt=0010 over T1..T6; cnt_clr at T1; cnt_en T2..T4; cnt_val 0..3 over T2..T5; done=0010 at T6; req dropped → IDLE at T7, busy=0.
2. Simultaneous requests (req=1111 at T0, all periods=2, each req dropped after its done) → grants in order 0,1,2,3; done at T5, T11, T17, T23; gnt never multi-hot.
3. Fairness (req[0] and req[2] re-asserted immediately after each done, period=1) → grant order alternates 0,2,0,2; neither is granted twice in a row.
4. Period extremes:
   - period_1=0 → cnt_en never high, done[1] at T3.
   - period_1=31 → cnt_en high for 31 cycles, cnt_val reaches 31 with no wrap, done[1] at T34.
5. Withdrawal (req[3] drops at cnt_val=5, period_3=10) → next cycle gnt=0000, IDLE, no done; a subsequent req=1001 grants requester 0 first (ptr=0).
6. Mid-transaction reset (rst pulsed during COUNT) → gnt/cnt_en/busy go 0 asynchronously; no done; after release, a req=0100 is granted from IDLE with ptr=0.
7. Period change after grant (period_2 changed from 4 to 9 at T3 after grant) → count still ends at cnt_val=4; done[2] at T7.

Source files
------------

// File: rtl/timer_share_ctrl.sv
// rtl/timer_share_ctrl.sv - round-robin time-sharing of one up-counter among N_REQ delay requesters
module timer_share_ctrl #(
  parameter int N_REQ       = 4,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*COUNT_WIDTH-1:0] period_i,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             done,
  output logic                         busy,
  output logic                         cnt_clr,
  output logic                         cnt_en,
  input  logic [COUNT_WIDTH-1:0]       cnt_val
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       idx_inc;
  logic [COUNT_WIDTH-1:0] period_r;
  logic                   sel_found;
  logic                   at_period;
  logic                   withdrawn;
  logic                   advance_ptr;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!sel_found && req[(int'(ptr) + i) % N_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign idx_inc     = (idx_r == IDX_W'(N_REQ - 1)) ? '0 : idx_r + 1'b1;
  assign at_period   = (cnt_val == period_r);
  assign withdrawn   = !req[idx_r];
  assign advance_ptr = (state == DONE) ||
                       (((state == CLEAR) || (state == COUNT)) && withdrawn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx_r    <= '0;
      period_r <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && sel_found) begin
        idx_r    <= sel_idx;
        period_r <= period_i[sel_idx*COUNT_WIDTH +: COUNT_WIDTH];
      end
      if (advance_ptr) begin
        ptr <= idx_inc;
      end
    end
  end

  // Withdrawal wins over reaching the period: a dropped request never sees done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sel_found) state_nxt = CLEAR;
      CLEAR: state_nxt = withdrawn ? IDLE : COUNT;
      COUNT: begin
        if (withdrawn) begin
          state_nxt = IDLE;
        end else if (at_period) begin
          state_nxt = DONE;
        end
      end
      DONE:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    done    = '0;
    busy    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: ;
      CLEAR: begin
        gnt[idx_r] = 1'b1;
        busy       = 1'b1;
        cnt_clr    = 1'b1;
      end
      COUNT: begin
        gnt[idx_r] = 1'b1;
        busy       = 1'b1;
        cnt_en     = !at_period;
      end
      DONE: begin
        gnt[idx_r]  = 1'b1;
        done[idx_r] = 1'b1;
        busy        = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb/tb_timer_share_ctrl.sv - directed self-checking bench for timer_share_ctrl with an attached counter
module tb_timer_share_ctrl;

  localparam int N  = 4;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*CW-1:0] period_i;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic          busy;
  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt_val;

  int checks   = 0;
  int failures = 0;

  timer_share_ctrl #(.N_REQ(N), .COUNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .period_i (period_i),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .cnt_val  (cnt_val)
  );

  // Shared counter: async reset, sync clear, enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_val <= '0;
    else if (cnt_clr) cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_period(input int k, input logic [CW-1:0] v);
    period_i[k*CW +: CW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    period_i = '0;
    #2;
    checks++;
    if ({gnt, done, busy, cnt_clr, cnt_en} !== '0) begin
      failures++;
      $display("FAIL reset_during outputs=%b required=0", {gnt, done, busy, cnt_clr, cnt_en});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, done, busy, cnt_clr, cnt_en} !== '0) begin
      failures++;
      $display("FAIL reset_after outputs=%b required=0", {gnt, done, busy, cnt_clr, cnt_en});
    end
  endtask

  task automatic test_single();
    logic [N-1:0] eg, ed;
    do_reset();
    set_period(1, 5'd3);
    req = 4'b0010;
    for (int t = 1; t <= 7; t++) begin
      tick();
      eg = (t <= 6) ? 4'b0010 : 4'b0000;
      ed = (t == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL single_gnt t=%0d got=%b exp=%b", t, gnt, eg);
      end
      checks++;
      if (done !== ed) begin
        failures++;
        $display("FAIL single_done t=%0d got=%b exp=%b", t, done, ed);
      end
      checks++;
      if (cnt_clr !== (t == 1)) begin
        failures++;
        $display("FAIL single_clr t=%0d got=%b exp=%b", t, cnt_clr, (t == 1));
      end
      checks++;
      if (cnt_en !== (t >= 2 && t <= 4)) begin
        failures++;
        $display("FAIL single_en t=%0d got=%b exp=%b", t, cnt_en, (t >= 2 && t <= 4));
      end
      checks++;
      if (busy !== (t <= 6)) begin
        failures++;
        $display("FAIL single_busy t=%0d got=%b exp=%b", t, busy, (t <= 6));
      end
      if (t >= 2 && t <= 5) begin
        checks++;
        if (cnt_val !== CW'(t - 2)) begin
          failures++;
          $display("FAIL single_cnt t=%0d got=%0d exp=%0d", t, cnt_val, t - 2);
        end
      end
      if (t == 6) req = 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    int t;
    int n;
    logic [N-1:0] exp;
    do_reset();
    for (int k = 0; k < N; k++) set_period(k, 5'd2);
    req = 4'b1111;
    t = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      t++;
      checks++;
      if ($countones(gnt) > 1) begin
        failures++;
        $display("FAIL simul_onehot t=%0d got=%b exp=at_most_one", t, gnt);
      end
      if (done !== 4'b0000) begin
        exp = 4'b0001 << n;
        checks++;
        if (done !== exp) begin
          failures++;
          $display("FAIL simul_order n=%0d got=%b exp=%b", n, done, exp);
        end
        checks++;
        if (t !== 5 + 6 * n) begin
          failures++;
          $display("FAIL simul_time n=%0d got=%0d exp=%0d", n, t, 5 + 6 * n);
        end
        req = req & ~done;
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL simul_count got=%0d exp=4", n);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] order [4];
    logic [N-1:0] exp;
    int ng;
    int nd;
    do_reset();
    set_period(0, 5'd1);
    set_period(2, 5'd1);
    req = 4'b0101;
    ng = 0;
    nd = 0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      tick();
      if (cnt_clr && ng < 4) begin
        order[ng] = gnt;
        ng++;
      end
      if (done !== 4'b0000) begin
        nd++;
        if (nd == 4) req = 4'b0000;
      end
    end
    checks++;
    if (ng !== 4) begin
      failures++;
      $display("FAIL fair_grants got=%0d exp=4", ng);
    end
    for (int i = 0; i < 4 && i < ng; i++) begin
      exp = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (order[i] !== exp) begin
        failures++;
        $display("FAIL fair_order i=%0d got=%b exp=%b", i, order[i], exp);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fair_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_extremes();
    int t;
    int en_cnt;
    do_reset();
    set_period(1, 5'd0);
    req = 4'b0010;
    for (int tt = 1; tt <= 3; tt++) begin
      tick();
      checks++;
      if (cnt_en !== 1'b0) begin
        failures++;
        $display("FAIL p0_en t=%0d got=%b exp=0", tt, cnt_en);
      end
      checks++;
      if (done !== ((tt == 3) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL p0_done t=%0d got=%b exp=%b", tt, done, (tt == 3) ? 4'b0010 : 4'b0000);
      end
    end
    req = 4'b0000;
    tick();
    set_period(1, 5'd31);
    req = 4'b0010;
    t = 0;
    en_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      t++;
      if (cnt_en) en_cnt++;
      if (done !== 4'b0000) break;
    end
    checks++;
    if (done !== 4'b0010) begin
      failures++;
      $display("FAIL p31_done got=%b exp=0010", done);
    end
    checks++;
    if (t !== 34) begin
      failures++;
      $display("FAIL p31_time got=%0d exp=34", t);
    end
    checks++;
    if (en_cnt !== 31) begin
      failures++;
      $display("FAIL p31_en_cycles got=%0d exp=31", en_cnt);
    end
    checks++;
    if (cnt_val !== 5'd31) begin
      failures++;
      $display("FAIL p31_nowrap got=%0d exp=31", cnt_val);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw();
    logic hit;
    do_reset();
    set_period(3, 5'd10);
    req = 4'b1000;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (gnt == 4'b1000 && !cnt_clr && cnt_val == 5'd5) begin
        req = 4'b0000;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wd_reach got=0 exp=1");
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if ({gnt, done, busy} !== '0) begin
        failures++;
        $display("FAIL wd_abort t=%0d got=%b exp=0", t, {gnt, done, busy});
      end
    end
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wd_next_grant got=%b exp=0001", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    int t;
    do_reset();
    set_period(2, 5'd10);
    req = 4'b0100;
    for (int c = 0; c < 4; c++) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, busy, cnt_en} !== '0) begin
      failures++;
      $display("FAIL mr_async got=%b exp=0", {gnt, done, busy, cnt_en});
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 4'b0000) begin
      failures++;
      $display("FAIL mr_nodone got=%b exp=0000", done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0100 || cnt_clr !== 1'b1) begin
      failures++;
      $display("FAIL mr_regrant got=%b/%b exp=0100/1", gnt, cnt_clr);
    end
    t = 1;
    for (int c = 0; c < 20; c++) begin
      if (done !== 4'b0000) break;
      tick();
      t++;
    end
    checks++;
    if (done !== 4'b0100 || t !== 13) begin
      failures++;
      $display("FAIL mr_done got=%b@%0d exp=0100@13", done, t);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_period_change();
    do_reset();
    set_period(2, 5'd4);
    req = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) set_period(2, 5'd9);
      if (t == 6) begin
        checks++;
        if (cnt_val !== 5'd4 || cnt_en !== 1'b0) begin
          failures++;
          $display("FAIL pc_end got=%0d/%b exp=4/0", cnt_val, cnt_en);
        end
      end
      checks++;
      if (done !== ((t == 7) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL pc_done t=%0d got=%b exp=%b", t, done, (t == 7) ? 4'b0100 : 4'b0000);
      end
      if (t == 7) req = 4'b0000;
      if (t == 8) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL pc_idle got=%b exp=0", busy);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    period_i = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_extremes();
    test_withdraw();
    test_mid_reset();
    test_period_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
